// File: rtl/i2c_slave_if.sv
// User-side handshake of the I2C responder: the byte to send, the byte received,
// and the strobes/status that frame them.
interface i2c_slave_if;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       rd_req;
    logic       busy;

    modport slave  (input data_in, output data_out, data_valid, rd_req, busy);
    modport master (output data_in, input data_out, data_valid, rd_req, busy);
endinterface

// File: rtl/i2c_slave.sv
// Oversampling I2C responder at a fixed 7-bit address: byte writes land on data_out,
// byte reads are fetched from data_in. SDA is open-drain, SCL is never stretched.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    i2c_slave_if.slave usr
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    state_t     state, state_nxt;
    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       byte_done, byte_done_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic       busy_r, busy_nxt;
    logic [7:0] data_out_r, data_out_nxt;
    logic       dv_r, dv_nxt;
    logic       rdr_r, rdr_nxt;
    logic [7:0] rx_sh, rx_sh_nxt;
    logic [7:0] tx_sh, tx_sh_nxt;
    logic       rw, rw_nxt;
    logic       load_rd;
    logic       scl_rise, scl_fall, start_cond, stop_cond;

    assign i2c_sda        = sda_oe ? 1'b0 : 1'bz;
    assign usr.data_out   = data_out_r;
    assign usr.data_valid = dv_r;
    assign usr.rd_req     = rdr_r;
    assign usr.busy       = busy_r;

    // _p0/_p1 form the synchronizer; _p2 holds the previous synced value for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= i2c_scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= i2c_sda;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise   =  scl_p1 & ~scl_p2;
    assign scl_fall   = ~scl_p1 &  scl_p2;
    assign start_cond =  scl_p1 &  sda_p2 & ~sda_p1;
    assign stop_cond  =  scl_p1 & ~sda_p2 &  sda_p1;

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        byte_done_nxt = byte_done;
        sda_oe_nxt    = sda_oe;
        busy_nxt      = busy_r;
        data_out_nxt  = data_out_r;
        dv_nxt        = 1'b0;
        rdr_nxt       = 1'b0;
        rx_sh_nxt     = rx_sh;
        tx_sh_nxt     = tx_sh;
        rw_nxt        = rw;
        load_rd       = 1'b0;

        if (start_cond) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd7;
            byte_done_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
        end else if (stop_cond) begin
            state_nxt     = IDLE;
            bit_cnt_nxt   = 3'd7;
            byte_done_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                ADDR, WRITE: begin
                    // bits are counted on rising edges; the byte is acted on at the following fall
                    if (scl_rise) begin
                        rx_sh_nxt = {rx_sh[6:0], sda_p1};
                        if (bit_cnt == 3'd0) byte_done_nxt = 1'b1;
                        else                 bit_cnt_nxt   = bit_cnt - 3'd1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd7;
                        if (state == WRITE) begin
                            data_out_nxt = rx_sh;
                            dv_nxt       = 1'b1;
                            sda_oe_nxt   = 1'b1;
                            state_nxt    = WRITE_ACK;
                        end else if (rx_sh[7:1] == SLAVE_ADDR) begin
                            rw_nxt     = rx_sh[0];
                            sda_oe_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                            state_nxt  = ADDR_ACK;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        if (rw) load_rd   = 1'b1;
                        else    state_nxt = WRITE;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = READ_ACK;
                        end else begin
                            tx_sh_nxt   = {tx_sh[6:0], 1'b0};
                            sda_oe_nxt  = ~tx_sh[6];
                            bit_cnt_nxt = bit_cnt - 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    // byte_done here records that the master acknowledged
                    if (scl_rise) begin
                        if (sda_p1) state_nxt     = WAIT_STOP;
                        else        byte_done_nxt = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        load_rd = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (load_rd) begin
            tx_sh_nxt     = usr.data_in;
            rdr_nxt       = 1'b1;
            sda_oe_nxt    = ~usr.data_in[7];
            bit_cnt_nxt   = 3'd7;
            byte_done_nxt = 1'b0;
            state_nxt     = READ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd7;
            byte_done  <= 1'b0;
            sda_oe     <= 1'b0;
            busy_r     <= 1'b0;
            data_out_r <= 8'h00;
            dv_r       <= 1'b0;
            rdr_r      <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_done  <= byte_done_nxt;
            sda_oe     <= sda_oe_nxt;
            busy_r     <= busy_nxt;
            data_out_r <= data_out_nxt;
            dv_r       <= dv_nxt;
            rdr_r      <= rdr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh <= rx_sh_nxt;
        tx_sh <= tx_sh_nxt;
        rw    <= rw_nxt;
    end
endmodule
